// File: rtl/mux10_pkg.sv
// Shared constants, output-register state type and round-robin helpers for
// the ten-port arbiter.
package mux10_pkg;

    localparam int NREQ  = 10;
    localparam int SEL_W = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
        return (idx == 4'd9) ? 4'd0 : idx + 4'd1;
    endfunction

    // Returns {found, g}: first set request at or after ptr, wrapping 9->0.
    function automatic logic [SEL_W:0] rr_next(input logic [SEL_W-1:0] ptr,
                                               input logic [NREQ-1:0]  req);
        logic             found;
        logic [SEL_W-1:0] g;
        logic [SEL_W-1:0] idx;
        found = 1'b0;
        g     = ptr;
        idx   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[idx]) begin
                found = 1'b1;
                g     = idx;
            end
            idx = wrap_inc(idx);
        end
        return {found, g};
    endfunction

endpackage

// File: rtl/mux10.sv
// 10:1 word multiplexer; select codes 10..15 yield zero.
module mux10 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    input  logic [WIDTH-1:0] d8,
    input  logic [WIDTH-1:0] d9,
    input  logic [3:0]       s,
    output logic [WIDTH-1:0] y
);

    // Word select
    always_comb begin
        case (s)
            4'd0:    y = d0;
            4'd1:    y = d1;
            4'd2:    y = d2;
            4'd3:    y = d3;
            4'd4:    y = d4;
            4'd5:    y = d5;
            4'd6:    y = d6;
            4'd7:    y = d7;
            4'd8:    y = d8;
            4'd9:    y = d9;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mux10_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output channel
// among ten requesters through a mux10 datapath.
module mux10_rr_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    input  logic [WIDTH-1:0] d8,
    input  logic [WIDTH-1:0] d9,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    import mux10_pkg::*;

    if (NREQ != mux10_pkg::NREQ) begin : g_nreq_check
        $error("mux10_rr_arbiter: NREQ must be 10");
    end

    ostate_t          state_r;
    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W:0]   rr_s;
    logic             found_s;
    logic             load_s;
    logic [SEL_W-1:0] g_s;
    logic [SEL_W-1:0] sel_s;
    logic [WIDTH-1:0] y_s;

    mux10 #(.WIDTH(WIDTH)) u_mux (d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, sel_s, y_s);

    // Arbitration, grant and busy decode; grants are suppressed during reset
    always_comb begin
        rr_s      = rr_next(ptr_r, req_valid[9:0]);
        found_s   = rr_s[SEL_W];
        g_s       = rr_s[SEL_W-1:0];
        load_s    = (state_r == EMPTY) || out_ready;
        sel_s     = found_s ? g_s : ptr_r;
        req_ready = '0;
        if (found_s && load_s && rst_n) begin
            req_ready[g_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
        busy = (state_r == FULL) || (|req_valid);
    end

    assign out_valid = (state_r == FULL);

    // Output register FSM (EMPTY/FULL) and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= EMPTY;
            ptr_r    <= 4'd0;
            out_data <= '0;
            out_sel  <= 4'd0;
        end else if (load_s) begin
            if (found_s) begin
                state_r  <= FULL;
                out_data <= y_s;
                out_sel  <= g_s;
                ptr_r    <= wrap_inc(g_s);
            end else begin
                state_r <= EMPTY;
            end
        end else begin
            state_r <= state_r;
        end
    end

endmodule

// File: tb/tb_mux10_rr_arbiter.sv
// Randomized and directed bench for mux10_rr_arbiter with a queue scoreboard
// and an abstract round-robin reference model.
module tb_mux10_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] dv [10];
    logic [9:0]  req_valid;
    logic [9:0]  req_ready;
    logic [15:0] out_data;
    logic [3:0]  out_sel;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] data;
    } item_t;

    item_t       sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          m_ptr;
    bit          m_valid;
    logic [15:0] m_data;
    logic [3:0]  m_sel;
    int          wait_cnt [10];
    logic [9:0]  pend;

    always #5 clk = ~clk;

    mux10_rr_arbiter #(.WIDTH(16), .NREQ(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]), .d4(dv[4]),
        .d5(dv[5]), .d6(dv[6]), .d7(dv[7]), .d8(dv[8]), .d9(dv[9]),
        .req_valid(req_valid), .req_ready(req_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = 16'h0000;
        m_sel   = 4'd0;
        for (int i = 0; i < 10; i++) wait_cnt[i] = 0;
        sb.delete();
    endtask

    // One clock of stimulus, called just after a falling edge; returns the grant.
    task automatic cycle(input logic [9:0] rv, input bit ordy, input bit rnd_data,
                         output bit found, output int g);
        bit         load;
        int         idx;
        logic [9:0] exp_rdy;
        req_valid = rv;
        out_ready = ordy;
        #1;
        load  = !m_valid || ordy;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < 10; k++) begin
            idx = (m_ptr + k) % 10;
            if (!found && rv[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        exp_rdy = (found && load) ? (10'b1 << g) : 10'b0;
        chk("req_ready", {22'b0, req_ready}, {22'b0, exp_rdy});
        chk("busy", {31'b0, busy}, {31'b0, (m_valid || (rv != 10'b0))});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("out_data", {16'b0, out_data}, {16'b0, m_data});
        chk("out_sel", {28'b0, out_sel}, {28'b0, m_sel});
        for (int i = 0; i < 10; i++) begin
            if (!rv[i]) wait_cnt[i] = 0;
            else if (load && !(found && g == i)) wait_cnt[i]++;
        end
        if (found && load) begin
            chk("fairness", {31'b0, (wait_cnt[g] < 10)}, 32'd1);
            wait_cnt[g] = 0;
            sb.push_back({4'(g), dv[g]});
        end
        @(posedge clk);
        if (load) begin
            if (found) begin
                m_valid = 1'b1;
                m_data  = dv[g];
                m_sel   = 4'(g);
                m_ptr   = (g + 1) % 10;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        if (found && load && rnd_data) dv[g] = 16'($urandom);
        if (!(found && load)) found = 1'b0;
    endtask

    // Scoreboard monitor: pops whenever the consumer takes a word
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual_sel=%0d actual_data=%0h required=none", out_sel, out_data);
            end else begin
                item_t it;
                it = sb.pop_front();
                chk("sb_sel", {28'b0, out_sel}, {28'b0, it.sel});
                chk("sb_data", {16'b0, out_data}, {16'b0, it.data});
            end
        end
    end

    initial begin
        bit          f;
        int          g;
        logic [15:0] init_tab [10];
        init_tab = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E,
                     16'h000F, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
        for (int i = 0; i < 10; i++) dv[i] = init_tab[i];
        rst_n     = 1'b0;
        req_valid = 10'h000;
        out_ready = 1'b0;
        model_reset();
        #3;
        req_valid = 10'h3FF;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {16'b0, out_data}, 32'd0);
        chk("rst_out_sel", {28'b0, out_sel}, 32'd0);
        chk("rst_req_ready", {22'b0, req_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request
        cycle(10'h001, 1'b1, 1'b0, f, g);
        chk("t1_data", {16'b0, out_data}, 32'h000A);
        chk("t1_sel", {28'b0, out_sel}, 32'd0);

        // All ports requesting; pointer starts at 1, so last grant is port 0
        for (int n = 0; n < 10; n++) cycle(10'h3FF, 1'b1, 1'b0, f, g);
        chk("t2_last_sel", {28'b0, out_sel}, 32'd0);
        chk("t2_last_data", {16'b0, out_data}, 32'h000A);

        // Backpressure then one-cycle drain+load
        for (int n = 0; n < 3; n++) cycle(10'h3FF, 1'b0, 1'b0, f, g);
        cycle(10'h3FF, 1'b1, 1'b0, f, g);
        chk("t3_sel", {28'b0, out_sel}, 32'd1);
        chk("t3_data", {16'b0, out_data}, 32'h000B);

        // Skip and wrap: grant 7 -> ptr 8, then 9, then 2
        cycle(10'h000, 1'b1, 1'b0, f, g);
        cycle(10'h080, 1'b1, 1'b0, f, g);
        cycle(10'h204, 1'b1, 1'b0, f, g);
        chk("t4_sel9", {28'b0, out_sel}, 32'd9);
        chk("t4_data9", {16'b0, out_data}, 32'h0004);
        cycle(10'h004, 1'b1, 1'b0, f, g);
        chk("t4_sel2", {28'b0, out_sel}, 32'd2);
        chk("t4_data2", {16'b0, out_data}, 32'h000C);

        // Idle drain
        cycle(10'h000, 1'b0, 1'b0, f, g);
        cycle(10'h000, 1'b1, 1'b0, f, g);
        cycle(10'h000, 1'b0, 1'b0, f, g);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_hold", {16'b0, out_data}, 32'h000C);

        // Randomized traffic with requesters that may drop before grant
        pend = 10'h000;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 10; i++) begin
                if (pend[i] && ($urandom % 16 == 0)) pend[i] = 1'b0;
                else if (!pend[i] && ($urandom % 3 == 0)) pend[i] = 1'b1;
            end
            cycle(pend, ($urandom % 10) < 7, 1'b1, f, g);
            if (f) pend[g] = 1'b0;
        end

        // Asynchronous reset while a word is pending
        cycle(10'h3FF, 1'b0, 1'b0, f, g);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_out_data", {16'b0, out_data}, 32'd0);
        chk("t6_req_ready", {22'b0, req_ready}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(10'h3FF, 1'b1, 1'b0, f, g);
        chk("t6_first_sel", {28'b0, out_sel}, 32'd0);

        for (int n = 0; n < 20 && sb.size() > 0; n++) cycle(10'h000, 1'b1, 1'b0, f, g);
        #3;
        chk("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
